mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extracts load data, flags misaligned loads and qualifies the rd write.
// Define INSTRET_CNT_EN to build the retired-instruction counter; otherwise instret_o is tied to 0.
module mem_wb_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_rd_wren_i,
  input  logic [1:0]  mem_wb_sel_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_alu_data_i,
  input  logic [31:0] mem_pc4_i,
  input  logic [31:0] mem_ld_data_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_rd_wren_o,
  output logic [31:0] wb_rd_data_o,
  output logic        wb_misalign_o,
  output logic [31:0] instret_o
);

  logic        valid_q, valid_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        wren_q, wren_d;
  logic [31:0] data_q, data_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_res;
  logic        ld_mis;
  logic        ld_ill;
  logic        is_load;
  logic        cap_mis;
  logic        cap_bad;
  logic [31:0] cap_data;

  // Load extraction from the word-aligned data using the address byte offset.
  always_comb begin
    off     = mem_alu_data_i[1:0];
    ld_byte = mem_ld_data_i[7:0];
    unique case (off)
      2'd0: ld_byte = mem_ld_data_i[7:0];
      2'd1: ld_byte = mem_ld_data_i[15:8];
      2'd2: ld_byte = mem_ld_data_i[23:16];
      2'd3: ld_byte = mem_ld_data_i[31:24];
      default: ld_byte = mem_ld_data_i[7:0];
    endcase
    ld_half = off[1] ? mem_ld_data_i[31:16] : mem_ld_data_i[15:0];
    ld_res  = '0;
    ld_mis  = 1'b0;
    ld_ill  = 1'b0;
    case (mem_funct3_i)
      3'b000: ld_res = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_res = {24'h0, ld_byte};
      3'b001: begin
        ld_res = {{16{ld_half[15]}}, ld_half};
        ld_mis = off[0];
      end
      3'b101: begin
        ld_res = {16'h0, ld_half};
        ld_mis = off[0];
      end
      3'b010: begin
        ld_res = mem_ld_data_i;
        ld_mis = |off;
      end
      default: ld_ill = 1'b1;
    endcase
  end

  always_comb begin
    is_load = (mem_wb_sel_i == 2'b01);
    cap_mis = is_load & ld_mis;
    cap_bad = is_load & (ld_mis | ld_ill);
    case (mem_wb_sel_i)
      2'b01:   cap_data = cap_bad ? 32'h0 : ld_res;
      2'b10:   cap_data = mem_pc4_i;
      default: cap_data = mem_alu_data_i;
    endcase
  end

  // Flush beats stall; an invalid MEM instruction captures the same bubble as a flush.
  always_comb begin
    valid_d    = valid_q;
    rd_addr_d  = rd_addr_q;
    wren_d     = wren_q;
    data_d     = data_q;
    misalign_d = misalign_q;
    if (flush_i || (!stall_i && !mem_valid_i)) begin
      valid_d    = 1'b0;
      rd_addr_d  = '0;
      wren_d     = 1'b0;
      data_d     = '0;
      misalign_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = 1'b1;
      rd_addr_d  = mem_rd_addr_i;
      wren_d     = mem_rd_wren_i & (mem_rd_addr_i != 5'd0) & ~cap_bad;
      data_d     = cap_data;
      misalign_d = cap_mis;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      rd_addr_q  <= '0;
      wren_q     <= 1'b0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_addr_q  <= rd_addr_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  assign wb_valid_o    = valid_q;
  assign wb_rd_addr_o  = rd_addr_q;
  assign wb_rd_wren_o  = wren_q;
  assign wb_rd_data_o  = data_q;
  assign wb_misalign_o = misalign_q;

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_q, instret_d;

  // Counts the instruction leaving WB on this edge; wraps naturally at 32 bits.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !misalign_q && !stall_i) begin
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, corner sequences, random vs model.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [4:0]  mem_rd_addr_i = '0;
  logic        mem_rd_wren_i = 1'b0;
  logic [1:0]  mem_wb_sel_i = '0;
  logic [2:0]  mem_funct3_i = '0;
  logic [31:0] mem_alu_data_i = '0;
  logic [31:0] mem_pc4_i = '0;
  logic [31:0] mem_ld_data_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_rd_wren_o;
  logic [31:0] wb_rd_data_o;
  logic        wb_misalign_o;
  logic [31:0] instret_o;

  mem_wb_stage dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .mem_valid_i    (mem_valid_i),
    .mem_rd_addr_i  (mem_rd_addr_i),
    .mem_rd_wren_i  (mem_rd_wren_i),
    .mem_wb_sel_i   (mem_wb_sel_i),
    .mem_funct3_i   (mem_funct3_i),
    .mem_alu_data_i (mem_alu_data_i),
    .mem_pc4_i      (mem_pc4_i),
    .mem_ld_data_i  (mem_ld_data_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_rd_wren_o   (wb_rd_wren_o),
    .wb_rd_data_o   (wb_rd_data_o),
    .wb_misalign_o  (wb_misalign_o),
    .instret_o      (instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall, flush, valid;
    logic [4:0]  rd;
    logic        wren;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, pc4, ld;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic        e_wren;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what WB should hold and the retired count.
  logic        m_valid = 1'b0;
  logic [4:0]  m_rd = '0;
  logic        m_wren = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_instret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected WB contents for one MEM instruction, straight from the load rules.
  task automatic model_capture(input vin_t v, output logic ok_valid, output logic [4:0] rd,
                               output logic wren, output logic [31:0] data, output logic mis);
    int unsigned off;
    logic [31:0] b, h;
    logic bad;
    off  = int'(v.alu % 4);
    b    = (v.ld >> (8 * off)) & 32'hFF;
    h    = (v.ld >> (16 * (off / 2))) & 32'hFFFF;
    mis  = 1'b0;
    bad  = 1'b0;
    data = v.alu;
    if (v.sel == 2'd2) data = v.pc4;
    if (v.sel == 2'd1) begin
      case (v.f3)
        3'd0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd4: data = b;
        3'd1: begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (off % 2 == 1); end
        3'd5: begin data = h; mis = (off % 2 == 1); end
        3'd2: begin data = v.ld; mis = (off != 0); end
        default: bad = 1'b1;
      endcase
      if (mis || bad) begin
        data = 32'h0;
        bad  = 1'b1;
      end
    end
    ok_valid = 1'b1;
    rd       = v.rd;
    wren     = v.wren && (v.rd != 0) && !bad;
  endtask

  task automatic model_edge(input vin_t v);
    logic nv, nw, nm;
    logic [4:0] nr;
    logic [31:0] nd;
`ifdef INSTRET_CNT_EN
    if (m_valid && !m_mis && !v.stall) m_instret = m_instret + 1;
`endif
    if (v.flush || (!v.stall && !v.valid)) begin
      m_valid = 0; m_rd = 0; m_wren = 0; m_data = 0; m_mis = 0;
    end else if (!v.stall) begin
      model_capture(v, nv, nr, nw, nd, nm);
      m_valid = nv; m_rd = nr; m_wren = nw; m_data = nd; m_mis = nm;
    end
  endtask

  task automatic drive(input vin_t v);
    stall_i = v.stall; flush_i = v.flush; mem_valid_i = v.valid;
    mem_rd_addr_i = v.rd; mem_rd_wren_i = v.wren; mem_wb_sel_i = v.sel;
    mem_funct3_i = v.f3; mem_alu_data_i = v.alu; mem_pc4_i = v.pc4; mem_ld_data_i = v.ld;
  endtask

  // Apply inputs, clock one edge, update the model, sample 1 ns after the edge.
  task automatic cycle(input vin_t v);
    drive(v);
    @(posedge clk_i);
    model_edge(v);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid_o), 32'(m_valid));
    chk({tag, ".rd"}, 32'(wb_rd_addr_o), 32'(m_rd));
    chk({tag, ".wren"}, 32'(wb_rd_wren_o), 32'(m_wren));
    chk({tag, ".data"}, wb_rd_data_o, m_data);
    chk({tag, ".mis"}, 32'(wb_misalign_o), 32'(m_mis));
    chk({tag, ".instret"}, instret_o, m_instret);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid_o), 32'h0);
    chk({tag, ".rd"}, 32'(wb_rd_addr_o), 32'h0);
    chk({tag, ".wren"}, 32'(wb_rd_wren_o), 32'h0);
    chk({tag, ".data"}, wb_rd_data_o, 32'h0);
    chk({tag, ".mis"}, 32'(wb_misalign_o), 32'h0);
    chk({tag, ".instret"}, instret_o, 32'h0);
  endtask

  function automatic vin_t mk(input logic s, input logic f, input logic va, input logic [4:0] rd,
                              input logic we, input logic [1:0] sel, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] ld);
    vin_t v;
    v.stall = s; v.flush = f; v.valid = va; v.rd = rd; v.wren = we; v.sel = sel; v.f3 = f3;
    v.alu = alu; v.pc4 = pc4; v.ld = ld;
    return v;
  endfunction

  function automatic vin_t rnd_vin();
    vin_t v;
    v.stall = ($urandom_range(0, 4) == 0);
    v.flush = ($urandom_range(0, 9) == 0);
    v.valid = ($urandom_range(0, 4) != 0);
    v.rd    = 5'($urandom);
    v.wren  = 1'($urandom);
    v.sel   = 2'($urandom);
    v.f3    = 3'($urandom);
    v.alu   = $urandom;
    v.pc4   = $urandom;
    v.ld    = $urandom;
    return v;
  endfunction

  vec_t tbl[12];
  logic [31:0] snap_data, snap_instret;

  initial begin
    // Directed vectors: {inputs}, valid, rd, wren, data, misalign.
    tbl[0]  = '{mk(0,0,1,5'd5,1,2'b01,3'b000,32'h1003,32'h0,32'h80FF_0000),
                1, 5'd5, 1, 32'hFFFF_FF80, 0};
    tbl[1]  = '{mk(0,0,1,5'd6,1,2'b01,3'b101,32'h2002,32'h0,32'hBEEF_1234),
                1, 5'd6, 1, 32'h0000_BEEF, 0};
    tbl[2]  = '{mk(0,0,1,5'd7,1,2'b01,3'b010,32'h3001,32'h0,32'h1234_5678),
                1, 5'd7, 0, 32'h0, 1};
    tbl[3]  = '{mk(0,0,1,5'd1,1,2'b10,3'b000,32'h55,32'h0000_0104,32'h0),
                1, 5'd1, 1, 32'h0000_0104, 0};
    tbl[4]  = '{mk(0,0,1,5'd2,1,2'b11,3'b000,32'hCAFE_F00D,32'h4,32'h0),
                1, 5'd2, 1, 32'hCAFE_F00D, 0};
    tbl[5]  = '{mk(0,0,1,5'd3,1,2'b01,3'b011,32'h4000,32'h0,32'hFFFF_FFFF),
                1, 5'd3, 0, 32'h0, 0};
    tbl[6]  = '{mk(0,0,1,5'd4,1,2'b01,3'b001,32'h0,32'h0,32'h0000_8001),
                1, 5'd4, 1, 32'hFFFF_8001, 0};
    tbl[7]  = '{mk(0,0,1,5'd8,1,2'b01,3'b100,32'h5001,32'h0,32'h0000_AB00),
                1, 5'd8, 1, 32'h0000_00AB, 0};
    tbl[8]  = '{mk(0,0,1,5'd9,1,2'b01,3'b001,32'h6003,32'h0,32'h1234_5678),
                1, 5'd9, 0, 32'h0, 1};
    tbl[9]  = '{mk(0,0,0,5'd10,1,2'b00,3'b000,32'h7777,32'h0,32'h0),
                0, 5'd0, 0, 32'h0, 0};
    tbl[10] = '{mk(0,0,1,5'd0,1,2'b00,3'b000,32'hDEAD_BEEF,32'h0,32'h0),
                1, 5'd0, 0, 32'hDEAD_BEEF, 0};
    tbl[11] = '{mk(1,1,1,5'd11,1,2'b00,3'b000,32'h1111,32'h0,32'h0),
                0, 5'd0, 0, 32'h0, 0};

    #3;
    check_zero("reset");
    @(posedge clk_i);
    #1;
    check_zero("reset_held");
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].in);
      chk($sformatf("vec%0d.valid", i), 32'(wb_valid_o), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.rd", i), 32'(wb_rd_addr_o), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d.wren", i), 32'(wb_rd_wren_o), 32'(tbl[i].e_wren));
      chk($sformatf("vec%0d.data", i), wb_rd_data_o, tbl[i].e_data);
      chk($sformatf("vec%0d.mis", i), 32'(wb_misalign_o), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d.instret", i), instret_o, m_instret);
    end

    // Stall for three cycles with fresh inputs: WB and instret must hold.
    cycle(mk(0,0,1,5'd12,1,2'b00,3'b000,32'hA5A5_0001,32'h0,32'h0));
    chk("pre_stall.data", wb_rd_data_o, 32'hA5A5_0001);
    snap_data    = m_data;
    snap_instret = m_instret;
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1,0,1,5'(13 + i),1,2'b00,3'b000,$urandom,32'h0,32'h0));
      chk($sformatf("stall%0d.data", i), wb_rd_data_o, snap_data);
      chk($sformatf("stall%0d.rd", i), 32'(wb_rd_addr_o), 32'd12);
      chk($sformatf("stall%0d.instret", i), instret_o, snap_instret);
    end

    for (int i = 0; i < 400; i++) begin
      cycle(rnd_vin());
      check_model($sformatf("rnd%0d", i));
    end

    // Counter wrap: preload just below the top, then retire two instructions.
    cycle(mk(0,0,1,5'd1,1,2'b00,3'b000,32'h1,32'h0,32'h0));
`ifdef INSTRET_CNT_EN
    dut.instret_q = 32'hFFFF_FFFF;
    m_instret     = 32'hFFFF_FFFF;
`endif
    cycle(mk(0,0,1,5'd1,1,2'b00,3'b000,32'h2,32'h0,32'h0));
    cycle(mk(0,0,1,5'd1,1,2'b00,3'b000,32'h3,32'h0,32'h0));
`ifdef INSTRET_CNT_EN
    chk("wrap.instret", instret_o, 32'h0000_0001);
`endif
    check_model("wrap");

    // Asynchronous reset mid-stream, while a stall and flush are both requested.
    drive(mk(1,1,1,5'd4,1,2'b00,3'b000,32'h9,32'h0,32'h0));
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("async_rst");
    m_valid = 0; m_rd = 0; m_wren = 0; m_data = 0; m_mis = 0; m_instret = 0;
    @(posedge clk_i);
    #1;
    check_zero("rst_hold");
    rst_ni = 1'b1;
    cycle(mk(0,0,1,5'd31,1,2'b01,3'b000,32'h0,32'h0,32'h0000_007F));
    chk("first_cap.data", wb_rd_data_o, 32'h0000_007F);
    check_model("first_cap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
